// File: rtl/sat_accum_pkg.sv
// Shared filter-datapath definitions: symmetric saturation limits and the
// {data, ch, sat} result record used by the accumulator output stage.
package sat_accum_pkg;

   localparam int FILT_WIDTH    = 32;
   localparam int FILT_CHANNELS = 4;
   localparam int FILT_CH_W     = (FILT_CHANNELS > 1) ? $clog2(FILT_CHANNELS) : 1;

   typedef struct packed {
      logic [FILT_WIDTH-1:0] data;
      logic [FILT_CH_W-1:0]  ch;
      logic                  sat;
   } result_t;

   // Limits are symmetric: MIN = -MAX, so the most negative code never appears.
   function automatic logic signed [63:0] sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int width);
      return -sat_max(width);
   endfunction

endpackage

// File: rtl/sat_accum_sat_add.sv
// Combinational signed adder with symmetric saturation; reusable by other
// filter stages. sat_hit flags any sum that had to be clamped.
module sat_add
   import sat_accum_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             sat_hit
);

   localparam logic signed [63:0] MAX64 = sat_max(WIDTH);
   localparam logic signed [63:0] MIN64 = sat_min(WIDTH);
   localparam logic signed [WIDTH:0] MAX_S = MAX64[WIDTH:0];
   localparam logic signed [WIDTH:0] MIN_S = MIN64[WIDTH:0];

   logic signed [WIDTH:0] s;

   always_comb begin
      s       = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
      sum     = s[WIDTH-1:0];
      sat_hit = 1'b0;
      if (s > MAX_S) begin
         sum     = MAX_S[WIDTH-1:0];
         sat_hit = 1'b1;
      end else if (s < MIN_S) begin
         sum     = MIN_S[WIDTH-1:0];
         sat_hit = 1'b1;
      end
   end

endmodule

// File: rtl/sat_accum.sv
// Multi-channel saturating accumulator: per-channel running sums with sticky
// saturation flags, a single-entry output register and ready/valid handshake.
module sat_accum
   import sat_accum_pkg::*;
#(
   parameter int WIDTH    = FILT_WIDTH,
   parameter int CHANNELS = FILT_CHANNELS,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CH_W-1:0]  in_ch,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CH_W-1:0]  out_ch,
   output logic             out_sat
);

   logic [WIDTH-1:0] acc_q  [CHANNELS];
   logic             flag_q [CHANNELS];
   logic [WIDTH-1:0] acc_rd;
   logic             flag_rd;
   logic             ch_ok;
   logic             accept;
   logic [WIDTH-1:0] sum;
   logic             sat_hit;
   logic             out_valid_q, out_valid_d;
   result_t          out_q, out_d;

   // Register-vector read so the same channel can be hit every cycle.
   always_comb begin
      acc_rd  = '0;
      flag_rd = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (in_ch == CH_W'(c)) begin
            acc_rd  = acc_q[c];
            flag_rd = flag_q[c];
         end
      end
   end

   generate
      if ((2 ** CH_W) > CHANNELS) begin : g_range
         assign ch_ok = (in_ch < CH_W'(CHANNELS));
      end else begin : g_full
         assign ch_ok = 1'b1;
      end
   endgenerate

   assign in_ready = !clear && (!out_valid_q || out_ready);
   // Out-of-range channels complete the handshake but update nothing.
   assign accept   = in_valid && in_ready && ch_ok;

   sat_add #(.WIDTH(WIDTH)) u_add (
      .a       (acc_rd),
      .b       (in_data),
      .sum     (sum),
      .sat_hit (sat_hit)
   );

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_q[gi]  <= '0;
               flag_q[gi] <= 1'b0;
            end else if (clear) begin
               acc_q[gi]  <= '0;
               flag_q[gi] <= 1'b0;
            end else if (accept && (in_ch == CH_W'(gi))) begin
               if (in_last) begin
                  acc_q[gi]  <= '0;
                  flag_q[gi] <= 1'b0;
               end else begin
                  acc_q[gi]  <= sum;
                  flag_q[gi] <= flag_q[gi] | sat_hit;
               end
            end
         end
      end
   endgenerate

   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (accept && in_last) begin
         out_valid_d = 1'b1;
         out_d.data  = sum;
         out_d.ch    = in_ch;
         out_d.sat   = flag_rd | sat_hit;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_q.data;
   assign out_ch    = out_q.ch;
   assign out_sat   = out_q.sat;

endmodule

// File: tb/tb_sat_accum.sv
// Directed bench for sat_accum: hand-computed sums, saturation corners,
// interleaving with backpressure, clear and asynchronous reset.
module tb_sat_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_ch;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_ch;
   logic        out_sat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sat_accum #(.WIDTH(32), .CHANNELS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ch     (in_ch),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_sat   (out_sat)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Presents one beat just after an edge and holds it through the next edge.
   task automatic drive(input logic [1:0] ch, input logic [31:0] data, input logic last);
      in_valid = 1'b1;
      in_ch    = ch;
      in_data  = data;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ch     = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_data", 64'(out_data), 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'h1);

      // Plain two-beat sum on channel 0
      drive(2'd0, 32'h003F_FFFF, 1'b0);
      drive(2'd0, 32'h0021_47AD, 1'b1);
      check("sum_valid", 64'(out_valid), 64'h1);
      check("sum_data", 64'(out_data), 64'h0061_47AC);
      check("sum_ch", 64'(out_ch), 64'h0);
      check("sum_sat", 64'(out_sat), 64'h0);

      // Positive overflow on channel 2 stays sticky until the last beat
      drive(2'd2, 32'h7FFF_FFFF, 1'b0);
      drive(2'd2, 32'h7FFF_FFFF, 1'b0);
      drive(2'd2, 32'h0000_0001, 1'b1);
      check("pos_data", 64'(out_data), 64'h7FFF_FFFF);
      check("pos_ch", 64'(out_ch), 64'h2);
      check("pos_sat", 64'(out_sat), 64'h1);
      drive(2'd2, 32'h0000_0005, 1'b1);
      check("rearm_data", 64'(out_data), 64'h5);
      check("rearm_sat", 64'(out_sat), 64'h0);

      // Negative limit on channel 1
      drive(2'd1, 32'h8000_0001, 1'b0);
      drive(2'd1, 32'h8000_0000, 1'b1);
      check("neg_data", 64'(out_data), 64'h8000_0001);
      check("neg_sat", 64'(out_sat), 64'h1);

      // Most negative code alone is clamped
      drive(2'd3, 32'h8000_0000, 1'b1);
      check("minin_data", 64'(out_data), 64'h8000_0001);
      check("minin_sat", 64'(out_sat), 64'h1);

      // Interleave channels 0 and 3, then two consecutive lasts under backpressure
      drive(2'd0, 32'd10, 1'b0);
      drive(2'd3, 32'd100, 1'b0);
      drive(2'd0, 32'd20, 1'b0);
      drive(2'd3, 32'd200, 1'b0);
      drive(2'd0, 32'd1, 1'b1);
      check("il_first_valid", 64'(out_valid), 64'h1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ch     = 2'd3;
      in_data   = 32'd2;
      in_last   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", 64'(in_ready), 64'h0);
         check("bp_hold_data", 64'(out_data), 64'd31);
         check("bp_hold_ch", 64'(out_ch), 64'h0);
         @(posedge clk);
         #1;
         check("bp_hold_valid", 64'(out_valid), 64'h1);
      end
      out_ready = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("il_second_valid", 64'(out_valid), 64'h1);
      check("il_second_data", 64'(out_data), 64'd302);
      check("il_second_ch", 64'(out_ch), 64'h3);
      @(posedge clk);
      #1;
      check("il_no_dup", 64'(out_valid), 64'h0);

      // clear blocks the handshake and wipes the partial sum
      drive(2'd0, 32'h55, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_ch    = 2'd0;
      in_data  = 32'h77;
      #1;
      check("clr_in_ready", 64'(in_ready), 64'h0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      drive(2'd0, 32'h10, 1'b1);
      check("clr_data", 64'(out_data), 64'h10);
      check("clr_sat", 64'(out_sat), 64'h0);

      // Asynchronous reset mid-sum with a pending output
      drive(2'd1, 32'h123, 1'b0);
      out_ready = 1'b0;
      drive(2'd2, 32'h9, 1'b1);
      check("pre_rst_valid", 64'(out_valid), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'h0);
      check("arst_data", 64'(out_data), 64'h0);
      check("arst_ch", 64'(out_ch), 64'h0);
      check("arst_sat", 64'(out_sat), 64'h0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'h1);
      drive(2'd1, 32'h7, 1'b1);
      check("arst_dropped", 64'(out_data), 64'h7);
      check("arst_drop_ch", 64'(out_ch), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sat_accum.md
# sat_accum

Multi-channel saturating accumulator for the digital filter datapath, the clocked successor to the combinational saturating adder. It sums a stream of signed fixed-point products per channel with symmetric saturation. On a beat marked last it emits the channel's final sum and re-arms that channel. It sits between the coefficient multipliers and the filter output register and supports interleaved channels and output backpressure.

## Interface
- WIDTH, 32: signed data width; the binary point is transparent to the block.
- CHANNELS, 4: number of independent accumulators, at least 1.
- CH_W, $clog2(CHANNELS) (minimum 1): channel index width, derived.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- clear  in  1  synchronous clear of all accumulators and sticky flags.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  signed addend.
- in_ch  in  CH_W  target channel. Values ≥ CHANNELS are accepted and discarded.
- in_last  in  1  final addend of this channel's sum.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  saturated sum.
- out_ch  out  CH_W  channel of the result.
- out_sat  out  1  saturation occurred at any point during this sum.

## Operation
- Limits: MAX = 2^(WIDTH-1)-1 and MIN = -MAX. The saturation is symmetric, so -2^(WIDTH-1) is never produced.
- Each accepted beat computes s = acc[in_ch] + in_data in WIDTH+1 bits, then clamps s to [MIN, MAX].
  - sat_hit is set when the clamp alters s.
  - An input of 0x8000_0000 added to 0 yields 0x8000_0001 with sat_hit set.
- Non-last beat: acc[in_ch] ← clamp(s) and flag[in_ch] ← flag[in_ch] | sat_hit.
- Last beat:
  - The output register loads clamp(s), in_ch and flag[in_ch] | sat_hit.
  - acc[in_ch] ← 0 and flag[in_ch] ← 0.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready). The combinational path from out_ready to in_ready is permitted.
  - A beat transfers when in_valid && in_ready.
- Output register:
  - Set on an accepted last beat.
  - Cleared on out_valid && out_ready when no new last beat loads in the same cycle. If a new last beat loads, it is overwritten.
  - out_data, out_ch and out_sat are stable while out_valid && !out_ready.
- clear:
  - Zeros every acc and flag.
  - Forces in_ready low, so no beat is lost silently.
  - Does not touch the output register.
- Reset: every acc and flag is 0, out_valid is 0, and out_data, out_ch and out_sat are 0.
- Reset asserted mid-sum drops all partial sums and any pending output.

## Timing
- Accumulate latency is 1 cycle: a beat accepted at edge t is visible in acc after edge t.
- Result latency is 1 cycle: a last beat accepted at edge t gives out_valid high after t.
- Back-to-back beats to the same channel run at full rate with no bubble, because acc is read and written in the same cycle.
- Consecutive last beats stream at 1 per cycle while out_ready is held high.
- When out_valid && !out_ready, in_ready is low and all state holds.

## Structure
- Shared filter package: sat_max(WIDTH), sat_min(WIDTH), and the typedef for the {data, ch, sat} result struct.
- Sub-module sat_add, parametrised by WIDTH and purely combinational:
  - Inputs: a, b.
  - Outputs: clamped sum and sat_hit.
  - Reusable by the other filter stages.
- The accumulator array is a register vector indexed by channel, not RAM, so a same-cycle read-modify-write is legal.

## Test plan
Each scenario uses WIDTH = 32 and CHANNELS = 4.
1. Reset value check: assert rst_n low mid-stream. Outputs read 0 immediately (asynchronously) and in_ready is 1 after release.
2. Channel 0 receives 0x3FFFFF, then 0x2147AD with last. Expect out_data = 0x6147AC, out_ch = 0, out_sat = 0.
3. Positive overflow: channel 2 receives 0x7FFFFFFF, 0x7FFFFFFF, then 0x1 with last. Expect out_data = 0x7FFFFFFF and out_sat = 1. A following channel-2 sum of 0x5 with last gives out_data = 0x5 and out_sat = 0.
4. Negative limit: channel 1 receives 0x80000001, then 0x80000000 with last. Expect out_data = 0x80000001 and out_sat = 1.
5. Interleave and backpressure:
   - Drive channels 0 and 3 with alternating beats, ending in two consecutive lasts.
   - Hold out_ready = 0 for 3 cycles.
   - Expect in_ready = 0 and the first result held stable.
   - Release: results arrive in order, with no beat lost and no beat duplicated.
6. clear: pulse clear with in_valid high on a partial channel-0 sum. Expect in_ready = 0 that cycle. The next channel-0 last beat of 0x10 returns exactly 0x10.
